axis_bus_demux: RTL



---
 rtl/axis_bus_demux_pkg.sv | 40 ++++
 rtl/axis_bus_demux_out_reg.sv | 44 ++++
 rtl/axis_bus_demux.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_bus_demux_pkg.sv
// ============================================================================
// Module   : axis_bus_pkg
// Purpose  : Shared constants, FSM state type and route-code decoder for the
//            AXIS packet demultiplexer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axis_bus_pkg;

    localparam logic [7:0] CHOOSE_FIFO_BASE = 8'd128;
    localparam int         NUM_PORTS        = 6;
    localparam int         DATA_W           = 32;
    localparam int         KEEP_W           = DATA_W / 8;
    localparam int         IDX_W            = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } sel_t;

    // Codes below the base wrap to large offsets, so one compare covers both ends.
    function automatic sel_t sel_decode(input logic [7:0] sel);
        sel_t       r;
        logic [7:0] off;
        off     = sel - CHOOSE_FIFO_BASE;
        r.valid = (off < 8'(NUM_PORTS));
        r.idx   = IDX_W'(off);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_bus_demux_out_reg.sv
// ============================================================================
// Module   : axis_out_reg
// Purpose  : One-entry AXI-Stream output register with load and drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_out_reg
    import axis_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] keep,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= in_data;
                keep  <= in_keep;
                last  <= in_last;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_bus_demux.sv
// ============================================================================
// Module   : axis_bus_demux
// Purpose  : Routes whole AXIS packets to one of six outputs by bus_sel.
//            Define AXIS_BUS_DEMUX_DROP_EN to discard packets with bad codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_bus_demux
    import axis_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        bus_sel,
    input  logic              axis_in_tvalid,
    output logic              axis_in_tready,
    input  logic [DATA_W-1:0] axis_in_tdata,
    input  logic [KEEP_W-1:0] axis_in_tkeep,
    input  logic              axis_in_tlast,
    output logic              axis_out_0_tvalid,
    input  logic              axis_out_0_tready,
    output logic [DATA_W-1:0] axis_out_0_tdata,
    output logic [KEEP_W-1:0] axis_out_0_tkeep,
    output logic              axis_out_0_tlast,
    output logic              axis_out_1_tvalid,
    input  logic              axis_out_1_tready,
    output logic [DATA_W-1:0] axis_out_1_tdata,
    output logic [KEEP_W-1:0] axis_out_1_tkeep,
    output logic              axis_out_1_tlast,
    output logic              axis_out_2_tvalid,
    input  logic              axis_out_2_tready,
    output logic [DATA_W-1:0] axis_out_2_tdata,
    output logic [KEEP_W-1:0] axis_out_2_tkeep,
    output logic              axis_out_2_tlast,
    output logic              axis_out_3_tvalid,
    input  logic              axis_out_3_tready,
    output logic [DATA_W-1:0] axis_out_3_tdata,
    output logic [KEEP_W-1:0] axis_out_3_tkeep,
    output logic              axis_out_3_tlast,
    output logic              axis_out_4_tvalid,
    input  logic              axis_out_4_tready,
    output logic [DATA_W-1:0] axis_out_4_tdata,
    output logic [KEEP_W-1:0] axis_out_4_tkeep,
    output logic              axis_out_4_tlast,
    output logic              axis_out_5_tvalid,
    input  logic              axis_out_5_tready,
    output logic [DATA_W-1:0] axis_out_5_tdata,
    output logic [KEEP_W-1:0] axis_out_5_tkeep,
    output logic              axis_out_5_tlast,
    output logic              busy,
    output logic [15:0]       drop_cnt
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     route_q;
    sel_t                 dec;
    logic [IDX_W-1:0]     target;
    logic                 tgt_ready;
    logic                 in_ready;
    logic                 load_en;
    logic                 accept;

    logic [NUM_PORTS-1:0] out_valid;
    logic [NUM_PORTS-1:0] out_ready;
    logic [NUM_PORTS-1:0] out_last;
    logic [NUM_PORTS-1:0] load;
    logic [DATA_W-1:0]    out_data [NUM_PORTS];
    logic [KEEP_W-1:0]    out_keep [NUM_PORTS];

    assign dec    = sel_decode(bus_sel);
    assign target = (state_q == PASS) ? route_q : dec.idx;

    always_comb begin
        tgt_ready = 1'b0;
        for (int n = 0; n < NUM_PORTS; n++) begin
            if (target == IDX_W'(n)) begin
                tgt_ready = !out_valid[n] || out_ready[n];
            end
        end
    end

    // Ready path is kept apart from next-state so accept does not loop back.
    always_comb begin
        in_ready = 1'b0;
        load_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dec.valid) begin
                    in_ready = tgt_ready;
                    load_en  = 1'b1;
                end else begin
`ifdef AXIS_BUS_DEMUX_DROP_EN
                    in_ready = 1'b1;
`else
                    in_ready = 1'b0;
`endif
                end
            end
            PASS: begin
                in_ready = tgt_ready;
                load_en  = 1'b1;
            end
            DROP: begin
                in_ready = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Held low while reset is asserted so nothing is offered upstream.
    assign axis_in_tready = in_ready && rst_n;
    assign accept         = axis_in_tvalid && axis_in_tready;
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !axis_in_tlast) begin
                    state_d = dec.valid ? PASS : DROP;
                end
            end
            PASS, DROP: begin
                if (accept && axis_in_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && accept && dec.valid) begin
                route_q <= dec.idx;
            end
        end
    end

`ifdef AXIS_BUS_DEMUX_DROP_EN
    logic        drop_evt;
    logic [15:0] drop_q;

    assign drop_evt = accept && axis_in_tlast &&
                      ((state_q == DROP) || (state_q == IDLE && !dec.valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop_evt && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'd0;
`endif

    generate
        for (genvar n = 0; n < NUM_PORTS; n++) begin : g_out
            assign load[n] = accept && load_en && (target == IDX_W'(n));

            axis_out_reg u_reg (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load[n]),
                .in_data (axis_in_tdata),
                .in_keep (axis_in_tkeep),
                .in_last (axis_in_tlast),
                .ready   (out_ready[n]),
                .valid   (out_valid[n]),
                .data    (out_data[n]),
                .keep    (out_keep[n]),
                .last    (out_last[n])
            );
        end
    endgenerate

    assign out_ready = {axis_out_5_tready, axis_out_4_tready, axis_out_3_tready,
                        axis_out_2_tready, axis_out_1_tready, axis_out_0_tready};

    assign axis_out_0_tvalid = out_valid[0];
    assign axis_out_0_tdata  = out_data[0];
    assign axis_out_0_tkeep  = out_keep[0];
    assign axis_out_0_tlast  = out_last[0];
    assign axis_out_1_tvalid = out_valid[1];
    assign axis_out_1_tdata  = out_data[1];
    assign axis_out_1_tkeep  = out_keep[1];
    assign axis_out_1_tlast  = out_last[1];
    assign axis_out_2_tvalid = out_valid[2];
    assign axis_out_2_tdata  = out_data[2];
    assign axis_out_2_tkeep  = out_keep[2];
    assign axis_out_2_tlast  = out_last[2];
    assign axis_out_3_tvalid = out_valid[3];
    assign axis_out_3_tdata  = out_data[3];
    assign axis_out_3_tkeep  = out_keep[3];
    assign axis_out_3_tlast  = out_last[3];
    assign axis_out_4_tvalid = out_valid[4];
    assign axis_out_4_tdata  = out_data[4];
    assign axis_out_4_tkeep  = out_keep[4];
    assign axis_out_4_tlast  = out_last[4];
    assign axis_out_5_tvalid = out_valid[5];
    assign axis_out_5_tdata  = out_data[5];
    assign axis_out_5_tkeep  = out_keep[5];
    assign axis_out_5_tlast  = out_last[5];

endmodule

`default_nettype wire
